// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core: operation select and operands in, registered results and NZCV flags out.
interface alu_core_if;
  logic [2:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUFlags;
  logic [31:0] Result;
  logic [31:0] ResultExtra;

  modport master (output ALUControl, A, B, input ALUFlags, Result, ResultExtra);
  modport slave  (input ALUControl, A, B, output ALUFlags, Result, ResultExtra);
endinterface

// File: rtl/alu_core.sv
// 32-bit ALU with one register stage: ADD/SUB/AND/ORR/EOR plus MUL/SMULL/UMULL and {N,Z,C,V} flags.
// Optional multiplier enabled by defining ALU_MUL_EN; otherwise multiply ops register zero with Z set.
module alu_core (
  input logic       clk,
  input logic       reset,
  alu_core_if.slave bus
);
  logic [31:0] res_d, res_q;
  logic [31:0] ext_d, ext_q;
  logic [3:0]  flags_d, flags_q;
  logic        c_d, v_d;
  logic [32:0] add_w, sub_w;

  assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_w = {1'b0, bus.A} + {1'b0, ~bus.B} + 33'd1;

`ifdef ALU_MUL_EN
  logic [63:0] prod_s, prod_u;
  // Low 64 bits of a 64x64 product of sign-extended operands is the signed 32x32 product.
  assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
`endif

  always_comb begin
    res_d = 32'd0;
    ext_d = 32'd0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (bus.ALUControl)
      3'b000: begin
        res_d = add_w[31:0];
        c_d   = add_w[32];
        v_d   = (bus.A[31] == bus.B[31]) && (add_w[31] != bus.A[31]);
      end
      3'b001: begin
        res_d = sub_w[31:0];
        c_d   = sub_w[32];
        v_d   = (bus.A[31] != bus.B[31]) && (sub_w[31] != bus.A[31]);
      end
      3'b010: res_d = bus.A & bus.B;
      3'b011: res_d = bus.A | bus.B;
      3'b100: res_d = bus.A ^ bus.B;
`ifdef ALU_MUL_EN
      3'b101: res_d = prod_u[31:0];
      3'b110: {ext_d, res_d} = prod_s;
      3'b111: {ext_d, res_d} = prod_u;
`endif
      default: ;
    endcase
    // ext_d is zero outside long multiplies, so the 64-bit zero test covers every op.
    flags_d = {(bus.ALUControl[2] & bus.ALUControl[1]) ? ext_d[31] : res_d[31],
               ({ext_d, res_d} == 64'd0), c_d, v_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q   <= 32'd0;
      ext_q   <= 32'd0;
      flags_q <= 4'b0000;
    end else begin
      res_q   <= res_d;
      ext_q   <= ext_d;
      flags_q <= flags_d;
    end
  end

  assign bus.Result      = res_q;
  assign bus.ResultExtra = ext_q;
  assign bus.ALUFlags    = flags_q;
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors push expectations, a negedge monitor pops and compares.
module tb_alu_core;
  logic clk;
  logic reset;
  alu_core_if bus ();

  alu_core dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [31:0] ext;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic drv_vld = 1'b0;
  logic out_vld;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Tracks which captured edges carry an issued vector.
  always @(posedge clk or negedge reset)
    if (!reset) out_vld <= 1'b0;
    else        out_vld <= drv_vld;

  always @(negedge clk) begin
    if (out_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard: output with empty queue, got %h", bus.Result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".res"},   bus.Result,             e.res);
        chk({e.name, ".ext"},   bus.ResultExtra,        e.ext);
        chk({e.name, ".flags"}, {28'd0, bus.ALUFlags},  {28'd0, e.flg});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [31:0] x, input logic [3:0] f,
                       input string name);
    exp_t e;
    @(negedge clk);
    bus.ALUControl = op;
    bus.A = a;
    bus.B = b;
    drv_vld = 1'b1;
    e.res = r; e.ext = x; e.flg = f; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    bus.ALUControl = 3'b111;
    bus.A = 32'hDEADBEEF;
    bus.B = 32'h12345678;
    #1 reset = 1'b0;
    #2;
    chk("rst.res",   bus.Result,            32'd0);
    chk("rst.ext",   bus.ResultExtra,       32'd0);
    chk("rst.flags", {28'd0, bus.ALUFlags}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    issue(3'b000, 32'd5,        32'd7,        32'd12,        32'd0, 4'b0000, "add5_7");
    issue(3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000,  32'd0, 4'b1001, "add_ovf");
    issue(3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,         32'd0, 4'b0110, "add_carry");
    issue(3'b001, 32'd3,        32'd5,        32'hFFFFFFFE,  32'd0, 4'b1000, "sub3_5");
    issue(3'b001, 32'd5,        32'd5,        32'd0,         32'd0, 4'b0110, "sub5_5");
    issue(3'b001, 32'h80000000, 32'd1,        32'h7FFFFFFF,  32'd0, 4'b0011, "sub_ovf");
    issue(3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,  32'd0, 4'b1000, "and");
    issue(3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0,  32'd0, 4'b1000, "orr");
    issue(3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0,  32'd0, 4'b0000, "eor");
`ifdef ALU_MUL_EN
    issue(3'b101, 32'd6,        32'd7,        32'd42,        32'd0, 4'b0000, "mul");
    issue(3'b110, 32'hFFFFFFD3, 32'd23,       32'hFFFFFBF5,  32'hFFFFFFFF, 4'b1000, "smull");
    issue(3'b111, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  32'd1, 4'b0000, "umull");
    issue(3'b111, 32'h80000000, 32'd2,        32'd0,         32'd1, 4'b0000, "umull_hi");
`else
    issue(3'b101, 32'd6,        32'd7,        32'd0,         32'd0, 4'b0100, "mul_off");
    issue(3'b110, 32'hFFFFFFD3, 32'd23,       32'd0,         32'd0, 4'b0100, "smull_off");
    issue(3'b111, 32'hFFFFFFFF, 32'd2,        32'd0,         32'd0, 4'b0100, "umull_off");
`endif
    issue(3'b110, 32'd0,        32'd5,        32'd0,         32'd0, 4'b0100, "smull_zero");
    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  32'd0, 4'b1010, "add_neg");
    @(negedge clk) drv_vld = 1'b0;

    // Inputs changing between edges must not disturb the held outputs.
    @(posedge clk);
    #2;
    bus.ALUControl = 3'b001;
    bus.A = 32'd1;
    bus.B = 32'd9;
    #1;
    chk("hold.res",   bus.Result,            32'hFFFFFFFE);
    chk("hold.flags", {28'd0, bus.ALUFlags}, 32'h0000000A);
    reset = 1'b0;
    #1;
    chk("midrst.res",   bus.Result,            32'd0);
    chk("midrst.flags", {28'd0, bus.ALUFlags}, 32'd0);
    @(negedge clk) reset = 1'b1;

    issue(3'b000, 32'd100, 32'd23, 32'd123, 32'd0, 4'b0000, "post_rst");
    @(negedge clk) drv_vld = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
